pipe_mips32: RTL and testbench
==============================

# pipe_mips32

Five-stage pipelined MIPS32-subset processor (IF, ID, EX, MEM, WB) with unified internal instruction/data memory and a 32×32 register file. It is a self-contained top-level core: the bench preloads the program and data through hierarchical access, releases reset, and reads the results back from memory.

## Interface
- No parameters. Memory depth is fixed at 1024 words and register count at 32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- The following internal names form part of the verification interface and must be kept exactly:
  - Mem[0:1023] (32-bit words, word-addressed)
  - Reg[0:31] (32-bit)
  - PC (32-bit)
  - HALTED (1-bit)
  - TAKEN_BRANCH (1-bit)

## Operation
- Instruction format:
  - Opcode is [31:26]; rs is [25:21]; rt is [20:16]; rd is [15:11].
  - imm is [15:0], sign-extended to 32 bits.
- Register-register ops write rd = rs op rt:
  - ADD 0, SUB 1, AND 2, OR 3.
  - SLT 4 (signed, result 1 or 0).
  - MUL 5 (low 32 bits of the product).
- Register-immediate ops write rt = rs op imm:
  - ADDI 10, SUBI 11.
  - SLTI 12 (signed).
- Memory ops:
  - LW 8: rt = Mem[rs+imm].
  - SW 9: Mem[rs+imm] = rt.
  - Address is the low 10 bits of the sum.
- Branches:
  - BNEQZ 13: taken if rs != 0.
  - BEQZ 14: taken if rs == 0.
  - Target = (branch PC + 1) + imm, in word units.
- HLT 63. Any other opcode executes as a NOP with no writes.
- Reg[0] reads as 0; writes to it are discarded. Arithmetic wraps modulo 2^32.
- PC is a word index. Fetch reads Mem[PC] and increments PC by 1 per cycle.
- Forwarding into EX operands (both rs and rt, including SW store data):
  - From EX/MEM for ALU results.
  - From MEM/WB for ALU and load results.
  - Register file is write-first, so WB data is visible to ID reads in the same cycle.
- No interlocks. A load result consumed by the immediately following instruction is undefined; software places one instruction between them.
- Branches resolve in EX. When taken:
  - PC <= target.
  - The two younger instructions in IF/ID and ID/EX become bubbles.
  - TAKEN_BRANCH is set for exactly that one cycle.
- HLT handling:
  - When HLT is decoded in ID, fetching stops: PC freezes and bubbles are issued.
  - Older instructions drain and complete normally.
  - HALTED sets when HLT reaches WB and stays set until rst.
  - While halted there are no register, memory or PC updates.
- Reset:
  - PC=0, HALTED=0, TAKEN_BRANCH=0; all pipeline registers hold bubbles.
  - Mem and Reg are not cleared.
  - Reset mid-program discards all in-flight instructions. Stores that committed before the reset edge remain.

## Timing
- Throughput is one instruction per cycle. An instruction fetched at cycle n writes back at cycle n+4.
- ALU result is forwardable to the next instruction; load result is forwardable to the instruction two behind.
- Taken-branch penalty is 2 cycles.
- HALTED asserts 4 cycles after HLT is fetched.
- SW writes memory at the rising edge that ends its MEM stage.

## Structure
- Shared package holds:
  - Opcode constants.
  - Instruction type encoding (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT).
  - Field bit positions.
- One natural sub-module, mips_alu: combinational, taking opcode and two 32-bit operands and producing a 32-bit result. Everything else stays in the top.

## Test plan
- Add/store program:
  - Preload Reg[k]=k and Mem[120]=85, then run: ADDI R1,R0,120 / OR R3,R3,R3 / LW R2,0(R1) / OR / ADDI R2,R2,45 / OR / SW R2,1(R1) / HLT.
  - Required: Mem[121]=130, Mem[120]=85, R1=120, R2=130, HALTED=1.
- Back-to-back ALU forwarding:
  - Run ADDI R1,R0,10 / ADDI R2,R1,20 / ADD R3,R2,R1 / HLT.
  - Required: R3=40.
- Branch loop:
  - Run R1=3, R2=0; loop ADDI R2,R2,5 / SUBI R1,R1,1 / BNEQZ R1,loop / HLT.
  - Required: R2=15; TAKEN_BRANCH pulses twice; the two instructions after each taken branch leave no effect.
- HLT drain:
  - Run instructions after HLT (e.g. ADDI R5,R0,7).
  - Required: R5 unchanged, PC frozen, no memory writes after HALTED.
- R0 and ops:
  - Run ADDI R0,R0,9; SLT and SLTI with negative immediates; MUL 6×7.
  - Required: R0=0, correct signed compares, product 42.
- Reset mid-run:
  - Assert rst for 1 cycle during the loop.
  - Required: PC=0, HALTED=0, TAKEN_BRANCH=0 next cycle; the program restarts from Mem[0].

Source files
------------

// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipe_mips32 core: opcodes, instruction classes,
// field positions and the packed pipeline-register layouts.
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // NOP is zero so that an all-zero pipeline register is a bubble
    typedef enum logic [2:0] {
        NOP    = 3'd0,
        RR_ALU = 3'd1,
        RM_ALU = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd6
    } itype_t;

    typedef struct packed {
        itype_t      ty;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        itype_t      ty;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        itype_t      ty;
        logic [4:0]  dest;
        logic [31:0] res;
    } mem_wb_t;

    function automatic itype_t decode_type(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    function automatic logic writes_reg(input itype_t t);
        return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
    endfunction

    function automatic logic is_alu(input itype_t t);
        return (t == RR_ALU) || (t == RM_ALU);
    endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Integer ALU for the EX stage; also forms load/store effective addresses.
// Latency: combinational, zero cycles.
// Backpressure: none, result follows operands in the same cycle.
module mips_alu
    import pipe_mips32_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: y = a + b;
            OP_SUB, OP_SUBI:               y = a - b;
            OP_AND:                        y = a & b;
            OP_OR:                         y = a | b;
            OP_SLT, OP_SLTI:               y = {31'b0, $signed(a) < $signed(b)};
            OP_MUL:                        y = a * b;
            default:                       y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with unified word memory and 32x32 register file.
// Latency: one instruction per cycle, writeback four cycles after fetch.
// Backpressure: none; taken branches cost two bubbles, HLT stops fetch and freezes.
module pipe_mips32
    import pipe_mips32_pkg::*;
(
    input  logic clk,
    input  logic rst
);

    logic [31:0] Mem [0:1023];
    logic [31:0] Reg [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        fetch_stop;
    logic        if_id_vld;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    id_ex_t      id_nxt;
    ex_mem_t     ex_nxt;
    mem_wb_t     mem_nxt;
    logic        wb_we;
    logic [31:0] ex_a, ex_b, alu_b, ex_y, br_target;
    logic        br_taken;

    assign wb_we = writes_reg(mem_wb.ty) && (mem_wb.dest != 5'd0);

    // ID: decode and read with write-first bypass from WB
    always_comb begin
        id_nxt      = '0;
        id_nxt.op   = if_id_ir[OPC_MSB:OPC_LSB];
        id_nxt.ty   = if_id_vld ? decode_type(id_nxt.op) : NOP;
        id_nxt.rs   = if_id_ir[RS_MSB:RS_LSB];
        id_nxt.rt   = if_id_ir[RT_MSB:RT_LSB];
        id_nxt.dest = (id_nxt.ty == RR_ALU) ? if_id_ir[RD_MSB:RD_LSB] : if_id_ir[RT_MSB:RT_LSB];
        id_nxt.imm  = {{16{if_id_ir[IMM_MSB]}}, if_id_ir[IMM_MSB:IMM_LSB]};
        id_nxt.npc  = if_id_npc;
        if (id_nxt.rs == 5'd0)
            id_nxt.a = '0;
        else if (wb_we && mem_wb.dest == id_nxt.rs)
            id_nxt.a = mem_wb.res;
        else
            id_nxt.a = Reg[id_nxt.rs];
        if (id_nxt.rt == 5'd0)
            id_nxt.b = '0;
        else if (wb_we && mem_wb.dest == id_nxt.rt)
            id_nxt.b = mem_wb.res;
        else
            id_nxt.b = Reg[id_nxt.rt];
    end

    // EX: newest producer wins; loads are only forwarded from MEM/WB
    always_comb begin
        ex_a = id_ex.a;
        ex_b = id_ex.b;
        if (wb_we && mem_wb.dest == id_ex.rs) ex_a = mem_wb.res;
        if (wb_we && mem_wb.dest == id_ex.rt) ex_b = mem_wb.res;
        if (is_alu(ex_mem.ty) && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rs) ex_a = ex_mem.alu;
        if (is_alu(ex_mem.ty) && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rt) ex_b = ex_mem.alu;
        alu_b     = (id_ex.ty == RR_ALU) ? ex_b : id_ex.imm;
        br_taken  = (id_ex.ty == BRANCH) &&
                    ((id_ex.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));
        br_target = id_ex.npc + id_ex.imm;
    end

    mips_alu u_alu (
        .op (id_ex.op),
        .a  (ex_a),
        .b  (alu_b),
        .y  (ex_y)
    );

    always_comb begin
        ex_nxt      = '0;
        ex_nxt.ty   = id_ex.ty;
        ex_nxt.dest = id_ex.dest;
        ex_nxt.alu  = ex_y;
        ex_nxt.b    = ex_b;
        mem_nxt      = '0;
        mem_nxt.ty   = ex_mem.ty;
        mem_nxt.dest = ex_mem.dest;
        mem_nxt.res  = (ex_mem.ty == LOAD) ? Mem[ex_mem.alu[9:0]] : ex_mem.alu;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop   <= 1'b0;
            if_id_vld    <= 1'b0;
            if_id_ir     <= '0;
            if_id_npc    <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= br_taken;
            ex_mem       <= ex_nxt;
            mem_wb       <= mem_nxt;
            if (mem_wb.ty == HALT)
                HALTED <= 1'b1;
            if (br_taken) begin
                PC        <= br_target;
                if_id_vld <= 1'b0;
                id_ex     <= '0;
            end else begin
                id_ex <= id_nxt;
                if (fetch_stop || id_nxt.ty == HALT) begin
                    fetch_stop <= 1'b1;
                    if_id_vld  <= 1'b0;
                end else begin
                    if_id_vld <= 1'b1;
                    if_id_ir  <= Mem[PC[9:0]];
                    if_id_npc <= PC + 32'd1;
                    PC        <= PC + 32'd1;
                end
            end
        end
    end

    // Architectural state keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!rst && !HALTED) begin
            if (ex_mem.ty == STORE)
                Mem[ex_mem.alu[9:0]] <= ex_mem.b;
            if (wb_we)
                Reg[mem_wb.dest] <= mem_wb.res;
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed programs for pipe_mips32 with hand-computed results.
module tb_pipe_mips32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   taken_cnt = 0;
    int   halt_cycles = 0;
    logic [31:0] pc_snap;

    always #5 clk = ~clk;

    pipe_mips32 dut (
        .clk (clk),
        .rst (rst)
    );

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset and wipe memory; the program is loaded afterwards while rst is high
    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n;
        n = 0;
        taken_cnt = 0;
        while (dut.HALTED !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
        end
        halt_cycles = n;
        check({tag, "_halted"}, {31'b0, dut.HALTED}, 32'd1);
    endtask

    task automatic load_loop();
        dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd3);      // ADDI R1,R0,3
        dut.Mem[1] = ri(6'd10, 5'd2, 5'd0, 16'd0);      // ADDI R2,R0,0
        dut.Mem[2] = ri(6'd10, 5'd2, 5'd2, 16'd5);      // loop: ADDI R2,R2,5
        dut.Mem[3] = ri(6'd11, 5'd1, 5'd1, 16'd1);      // SUBI R1,R1,1
        dut.Mem[4] = ri(6'd13, 5'd0, 5'd1, 16'hFFFD);   // BNEQZ R1,loop
        dut.Mem[5] = ri(6'd10, 5'd4, 5'd4, 16'd1);      // ADDI R4,R4,1
        dut.Mem[6] = ri(6'd10, 5'd6, 5'd6, 16'd1);      // ADDI R6,R6,1
        dut.Mem[7] = {6'd63, 26'd0};                    // HLT
        dut.Reg[2] = 32'd99;
        dut.Reg[4] = 32'd0;
        dut.Reg[6] = 32'd0;
    endtask

    initial begin
        // Reset state
        enter_reset();
        @(posedge clk);
        #1;
        check("reset_pc", dut.PC, 32'd0);
        check("reset_halted", {31'b0, dut.HALTED}, 32'd0);
        check("reset_taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);

        // Add/store program with load forwarding through MEM/WB
        @(negedge clk);
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        dut.Mem[120] = 32'd85;
        dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd120);
        dut.Mem[1] = rr(6'd3, 5'd3, 5'd3, 5'd3);
        dut.Mem[2] = ri(6'd8, 5'd2, 5'd1, 16'd0);
        dut.Mem[3] = rr(6'd3, 5'd3, 5'd3, 5'd3);
        dut.Mem[4] = ri(6'd10, 5'd2, 5'd2, 16'd45);
        dut.Mem[5] = rr(6'd3, 5'd3, 5'd3, 5'd3);
        dut.Mem[6] = ri(6'd9, 5'd2, 5'd1, 16'd1);
        dut.Mem[7] = {6'd63, 26'd0};
        release_reset();
        run_to_halt("t1", 200);
        check("t1_halt_latency", halt_cycles, 32'd12);
        check("t1_mem121", dut.Mem[121], 32'd130);
        check("t1_mem120", dut.Mem[120], 32'd85);
        check("t1_r1", dut.Reg[1], 32'd120);
        check("t1_r2", dut.Reg[2], 32'd130);
        check("t1_r3", dut.Reg[3], 32'd3);
        check("t1_pc", dut.PC, 32'd8);

        // Back-to-back ALU forwarding
        enter_reset();
        dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd10);
        dut.Mem[1] = ri(6'd10, 5'd2, 5'd1, 16'd20);
        dut.Mem[2] = rr(6'd0, 5'd3, 5'd2, 5'd1);
        dut.Mem[3] = {6'd63, 26'd0};
        release_reset();
        run_to_halt("t2", 200);
        check("t2_r2", dut.Reg[2], 32'd30);
        check("t2_r3", dut.Reg[3], 32'd40);
        check("t2_halt_latency", halt_cycles, 32'd8);

        // Branch loop: three passes, two taken branches, shadow slots squashed
        enter_reset();
        load_loop();
        release_reset();
        run_to_halt("t3", 300);
        check("t3_r2", dut.Reg[2], 32'd15);
        check("t3_r1", dut.Reg[1], 32'd0);
        check("t3_taken_pulses", taken_cnt, 32'd2);
        check("t3_r4_shadow", dut.Reg[4], 32'd1);
        check("t3_r6_shadow", dut.Reg[6], 32'd1);

        // HLT drain: nothing after HLT may take effect, state frozen once halted
        enter_reset();
        dut.Reg[5] = 32'd55;
        dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd5);
        dut.Mem[1] = ri(6'd9, 5'd1, 5'd0, 16'd200);
        dut.Mem[2] = {6'd63, 26'd0};
        dut.Mem[3] = ri(6'd10, 5'd5, 5'd0, 16'd7);
        dut.Mem[4] = ri(6'd9, 5'd1, 5'd0, 16'd201);
        release_reset();
        run_to_halt("t4", 200);
        pc_snap = dut.PC;
        repeat (10) @(posedge clk);
        #1;
        check("t4_pc_value", dut.PC, 32'd3);
        check("t4_pc_frozen", dut.PC, pc_snap);
        check("t4_r5", dut.Reg[5], 32'd55);
        check("t4_mem200", dut.Mem[200], 32'd5);
        check("t4_mem201", dut.Mem[201], 32'd0);
        check("t4_still_halted", {31'b0, dut.HALTED}, 32'd1);

        // R0 discard, signed compares, MUL
        enter_reset();
        dut.Reg[0] = 32'd0;
        dut.Mem[0]  = ri(6'd10, 5'd0, 5'd0, 16'd9);
        dut.Mem[1]  = ri(6'd10, 5'd1, 5'd0, 16'd6);
        dut.Mem[2]  = ri(6'd10, 5'd2, 5'd0, 16'd7);
        dut.Mem[3]  = rr(6'd5, 5'd3, 5'd1, 5'd2);
        dut.Mem[4]  = ri(6'd10, 5'd4, 5'd0, 16'hFFFB);
        dut.Mem[5]  = rr(6'd4, 5'd5, 5'd4, 5'd1);
        dut.Mem[6]  = rr(6'd4, 5'd6, 5'd1, 5'd4);
        dut.Mem[7]  = ri(6'd12, 5'd7, 5'd4, 16'hFFFD);
        dut.Mem[8]  = ri(6'd12, 5'd8, 5'd1, 16'hFFFF);
        dut.Mem[9]  = rr(6'd1, 5'd9, 5'd4, 5'd1);
        dut.Mem[10] = rr(6'd2, 5'd10, 5'd1, 5'd2);
        dut.Mem[11] = {6'd63, 26'd0};
        release_reset();
        run_to_halt("t5", 200);
        check("t5_r0", dut.Reg[0], 32'd0);
        check("t5_r1", dut.Reg[1], 32'd6);
        check("t5_mul", dut.Reg[3], 32'd42);
        check("t5_r4", dut.Reg[4], 32'hFFFF_FFFB);
        check("t5_slt_neg_lt", dut.Reg[5], 32'd1);
        check("t5_slt_pos_lt", dut.Reg[6], 32'd0);
        check("t5_slti_neg", dut.Reg[7], 32'd1);
        check("t5_slti_signed", dut.Reg[8], 32'd0);
        check("t5_sub_wrap", dut.Reg[9], 32'hFFFF_FFF5);
        check("t5_and", dut.Reg[10], 32'd6);

        // Reset mid-loop then restart from Mem[0]
        enter_reset();
        load_loop();
        release_reset();
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_pc", dut.PC, 32'd0);
        check("t6_halted", {31'b0, dut.HALTED}, 32'd0);
        check("t6_taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_first_fetch_pc", dut.PC, 32'd1);
        run_to_halt("t6", 300);
        check("t6_r2", dut.Reg[2], 32'd15);
        check("t6_r1", dut.Reg[1], 32'd0);
        check("t6_r4", dut.Reg[4], 32'd1);
        check("t6_taken_pulses", taken_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
